// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Issue/result bundle between the execute stage and the multi-cycle
//   multiply/divide unit.
//   master (execute stage): drives start, op, A, B; observes busy, done, dz, HI, LO.
//   slave  (muldiv unit)  : the reverse.
//   start : issue request, op : 0 = MULT / 1 = DIV, A/B : two's-complement operands.
//   busy  : operation in flight, done : one-cycle result pulse,
//   dz    : sticky divide-by-zero, HI/LO : result registers.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, done, dz, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, dz, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative signed MULT / DIV unit. Operands are reduced to magnitudes on
//   issue, WIDTH shift-add or restoring-divide iterations run one per cycle,
//   and the sign correction is applied when HI/LO are written.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     s   : muldiv_sequencer_if slave (start/op/A/B in, busy/done/dz/HI/LO out)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  muldiv_sequencer_if.slave  s
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Magnitude as an unsigned value; the most negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return unsigned'(v[WIDTH-1] ? -v : v);
  endfunction

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MULT: {partial product high, remaining multiplier bits}
  // DIV : {partial remainder, dividend bits shifting into quotient bits}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right with the carry.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit; subtract only if it fits.
    // The remainder stays below the divisor, so the W-bit difference is exact.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s.start) begin
          op_d   = s.op;
          cnt_d  = '0;
          dz_d   = 1'b0;
          qneg_d = s.A[WIDTH-1] ^ s.B[WIDTH-1];
          rneg_d = s.A[WIDTH-1];
          if (s.op && (s.B == '0)) begin
            // Preload the divide-by-zero result so FIN just copies it out.
            dz_d    = 1'b1;
            acc_d   = {s.A, {WIDTH{1'b1}}};
            opnd_d  = '0;
            state_d = S_FIN;
          end else if (s.op) begin
            acc_d   = {{WIDTH{1'b0}}, mag($signed(s.A))};
            opnd_d  = mag($signed(s.B));
            state_d = S_RUN;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag($signed(s.B))};
            opnd_d  = mag($signed(s.A));
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = op_q ? div_next : mul_next;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          {hi_d, lo_d} = acc_q;
        end else if (op_q) begin
          lo_d = cneg(acc_q[WIDTH-1:0], qneg_q);
          hi_d = cneg(acc_q[2*WIDTH-1:WIDTH], rneg_q);
        end else begin
          {hi_d, lo_d} = cneg2(acc_q, qneg_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign s.busy = (state_q != S_IDLE);
  assign s.done = done_q;
  assign s.dz   = dz_q;
  assign s.HI   = hi_q;
  assign s.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer (WIDTH=32). Each issued op pushes
//   its reference result (computed with 64-bit signed arithmetic) into a
//   queue; a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e_m;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  int           done_cnt = 0;
  int           issued = 0;
  logic         hold_bad = 1'b0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.lat = W + 1;
    e.acc_cyc = 0;
    if (!o) begin
      r = sa * sb;
      e.hi = r[63:32];
      e.lo = r[31:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      r = sa / sb;
      e.lo = r[31:0];
      r = sa % sb;
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Monitor: busy length, HI/LO hold while busy, result at each done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        busy_cnt++;
        if (bus.HI !== last_hi || bus.LO !== last_lo) hold_bad = 1'b1;
      end
      if (bus.done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 expected no pending op");
        end else begin
          e_m = sbq.pop_front();
          check("HI", bus.HI, e_m.hi);
          check("LO", bus.LO, e_m.lo);
          check("dz", bus.dz, e_m.dz);
          check("done_latency", cyc - e_m.acc_cyc, e_m.lat);
          check("busy_cycles", busy_cnt, e_m.lat);
          check("hilo_hold", hold_bad, 0);
        end
        last_hi = bus.HI;
        last_lo = bus.LO;
        busy_cnt = 0;
        hold_bad = 1'b0;
      end
    end
  end

  // Called at a negedge; drives start once the unit is idle, returns at the
  // negedge after the accepting edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int   n = 0;
    exp_t e;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got busy=1 expected idle within 200 cycles");
      return;
    end
    bus.start = 1'b1;
    bus.op = o;
    bus.A = a;
    bus.B = b;
    e = model(o, a, b);
    @(negedge clk);
    e.acc_cyc = cyc;
    sbq.push_back(e);
    issued++;
    bus.start = 1'b0;
    bus.op = 1'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || bus.busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.dz, 0);
    check("rst_HI", bus.HI, 0);
    check("rst_LO", bus.LO, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back.
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b0, 32'd2, 32'd3);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Re-issue during RUN must be ignored.
    issue(1'b0, 32'd12345, 32'hFFFF_FD5A);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.A = 32'd77;
    bus.B = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Reset in the middle of a DIV.
    issue(1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_HI", bus.HI, 0);
    check("midrst_LO", bus.LO, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_pending", sbq.size(), 1);
    if (sbq.size() != 0) void'(sbq.pop_back());
    issued--;
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    busy_cnt = 0;
    hold_bad = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b1, 32'd9, 32'd3);

    // Randomized ops, back-to-back.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), pick(), pick());
    end
    drain();
    repeat (10) @(negedge clk);
    check("done_count", done_cnt, issued);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
